// File: rtl/data_mem_lsu.sv
// data_mem_lsu: word-organised data memory with an RV32-style load/store unit.
// Accepts one byte/half/word request per cycle and answers exactly one cycle
// later with the extended load data or a fault flag.
// Optional feature macro: DMEM_INIT_CLEAR_EN -- when defined, the array is
// zero-filled one word per cycle after every reset before requests are taken;
// when undefined, the memory is usable straight out of reset and keeps its
// contents across reset.
module data_mem_lsu #(
    parameter int DEPTH = 256,
    parameter int AW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [2:0]    req_funct3,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          init_done,
    output logic [31:0]   dm0
);

    localparam int LW = $clog2(DEPTH);

    // Storage array; deliberately has no reset so it maps onto plain RAM.
    logic [31:0]   r_mem [DEPTH];

    // Response registers.
    logic          r_rspValid;
    logic          r_rspErr;
    logic [31:0]   r_rspRdata;

    // Request decode.
    logic          w_fire;
    logic [LW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_funcOk;
    logic          w_misaligned;
    logic          w_oob;
    logic          w_err;
    logic          w_storeWe;
    logic [3:0]    w_byteEn;
    logic [31:0]   w_storeData;
    logic [31:0]   w_rdWord;
    logic [7:0]    w_byteSel;
    logic [15:0]   w_halfSel;
    logic [31:0]   w_loadData;

    // Clear engine handshake (constant when the clear feature is absent).
    logic          w_initDone;
    logic          w_clearWe;
    logic [LW-1:0] w_clearIdx;

`ifdef DMEM_INIT_CLEAR_EN
    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [LW-1:0] r_clrIdx;

    // State register: every reset restarts the zero-fill.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Clear counter walks word 0..DEPTH-1 while clearing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clrIdx <= '0;
        end else if (r_state == ST_INIT) begin
            r_clrIdx <= r_clrIdx + LW'(1);
        end
    end

    // Next state: leave INIT once the last word is being written; RUN is terminal.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            ST_INIT: begin
                if (r_clrIdx == LW'(DEPTH - 1)) begin
                    w_nextState = ST_RUN;
                end
            end
            ST_RUN:  w_nextState = ST_RUN;
            default: w_nextState = ST_INIT;
        endcase
    end

    // State outputs: clear writes during INIT, requests only in RUN.
    always_comb begin
        w_initDone = 1'b0;
        w_clearWe  = 1'b0;
        w_clearIdx = r_clrIdx;
        case (r_state)
            ST_INIT: w_clearWe  = 1'b1;
            ST_RUN:  w_initDone = 1'b1;
            default: w_clearWe  = 1'b0;
        endcase
    end
`else
    assign w_initDone = 1'b1;
    assign w_clearWe  = 1'b0;
    assign w_clearIdx = '0;
`endif

    assign init_done = w_initDone;
    assign req_ready = w_initDone;
    assign w_fire    = req_valid && req_ready;
    assign w_idx     = req_addr[LW+1:2];
    assign w_lane    = req_addr[1:0];

    // Any address bit at or above 4*DEPTH means the access is outside the array.
    assign w_oob     = (req_addr >> (LW + 2)) != '0;

    // Size decode and alignment check; unused funct3 codes fault for loads and stores alike.
    always_comb begin
        w_funcOk     = 1'b1;
        w_misaligned = 1'b0;
        case (req_funct3)
            3'b000, 3'b100: w_misaligned = 1'b0;
            3'b001, 3'b101: w_misaligned = req_addr[0];
            3'b010:         w_misaligned = (req_addr[1:0] != 2'b00);
            default:        w_funcOk     = 1'b0;
        endcase
    end

    assign w_err     = !w_funcOk || w_misaligned || w_oob;
    assign w_storeWe = w_fire && req_we && !w_err;

    // Store lane steering: replicate the right-aligned data and enable only the addressed lanes.
    always_comb begin
        w_byteEn    = 4'b0000;
        w_storeData = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_byteEn    = 4'b0001 << w_lane;
                w_storeData = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_byteEn    = w_lane[1] ? 4'b1100 : 4'b0011;
                w_storeData = {2{req_wdata[15:0]}};
            end
            2'b10:   w_byteEn = 4'b1111;
            default: w_byteEn = 4'b0000;
        endcase
    end

    // Array write port: clear engine has the port during INIT, stores otherwise.
    always_ff @(posedge clk) begin
        if (w_clearWe) begin
            r_mem[w_clearIdx] <= '0;
        end else if (w_storeWe) begin
            for (int b = 0; b < 4; b++) begin
                if (w_byteEn[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_storeData[8*b +: 8];
                end
            end
        end
    end

    // Read the array asynchronously so a load right after a store sees the new data.
    assign w_rdWord  = r_mem[w_idx];
    assign w_byteSel = w_rdWord[{w_lane, 3'b000} +: 8];
    assign w_halfSel = w_lane[1] ? w_rdWord[31:16] : w_rdWord[15:0];

    // Load extraction with sign or zero extension.
    always_comb begin
        w_loadData = '0;
        case (req_funct3)
            3'b000:  w_loadData = {{24{w_byteSel[7]}}, w_byteSel};
            3'b001:  w_loadData = {{16{w_halfSel[15]}}, w_halfSel};
            3'b010:  w_loadData = w_rdWord;
            3'b100:  w_loadData = {24'h000000, w_byteSel};
            3'b101:  w_loadData = {16'h0000, w_halfSel};
            default: w_loadData = '0;
        endcase
    end

    // Response stage: one pulse per accepted request, data zero for stores and faults.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rspValid <= 1'b0;
            r_rspErr   <= 1'b0;
            r_rspRdata <= '0;
        end else begin
            r_rspValid <= w_fire;
            r_rspErr   <= w_fire && w_err;
            r_rspRdata <= (w_fire && !w_err && !req_we) ? w_loadData : '0;
        end
    end

    assign rsp_valid = r_rspValid;
    assign rsp_err   = r_rspErr;
    assign rsp_rdata = r_rspRdata;
    assign dm0       = r_mem[0];

endmodule

// File: tb/tb_data_mem_lsu.sv
// tb_data_mem_lsu: self-checking bench for data_mem_lsu (DEPTH=256).
// Reference model is a flat byte array updated by plain load/store rules.
module tb_data_mem_lsu;

    localparam int DEPTH = 256;
    localparam int AW    = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [2:0]    req_funct3 = 3'b000;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          init_done;
    logic [31:0]   dm0;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0]  refMem [4*DEPTH];

    logic        expErr;
    logic [31:0] expData;
    logic        obsReady;
    logic        obsValid;
    logic        obsErr;
    logic [31:0] obsData;
    logic [31:0] obsDm0;

`ifdef DMEM_INIT_CLEAR_EN
    localparam logic EXP_INIT_IN_RESET = 1'b0;
`else
    localparam logic EXP_INIT_IN_RESET = 1'b1;
`endif

    data_mem_lsu #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .init_done  (init_done),
        .dm0        (dm0)
    );

    always #5 clk = ~clk;

    // Reference behaviour of one request: returns the expected fault/data and updates the byte array.
    task automatic modelApply(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic eErr, output logic [31:0] eData);
        int size;
        logic isSigned;
        logic [31:0] v;
        size = 0;
        isSigned = 1'b0;
        case (f3)
            3'd0: begin size = 1; isSigned = 1'b1; end
            3'd1: begin size = 2; isSigned = 1'b1; end
            3'd2: size = 4;
            3'd4: size = 1;
            3'd5: size = 2;
            default: size = 0;
        endcase
        eErr = (size == 0) || (size == 2 && addr % 2 != 0) || (size == 4 && addr % 4 != 0)
               || (addr >= 32'(4*DEPTH));
        eData = '0;
        if (!eErr) begin
            if (we) begin
                for (int i = 0; i < size; i++) refMem[addr + i] = wdata[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < size; i++) v = v | (32'(refMem[addr + i]) << (8*i));
                if (isSigned && size < 4 && v >= (32'd1 << (8*size - 1)))
                    v = v - (32'd1 << (8*size));
                eData = v;
            end
        end
    endtask

    function automatic logic [31:0] refWord(input int addr);
        return {refMem[addr+3], refMem[addr+2], refMem[addr+1], refMem[addr]};
    endfunction

    task automatic zeroModel();
        for (int i = 0; i < 4*DEPTH; i++) refMem[i] = 8'h00;
    endtask

    // Drive one request for one cycle and capture the response after the edge.
    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        obsReady   = req_ready;
        modelApply(we, f3, addr, wdata, expErr, expData);
        @(posedge clk);
        #1;
        obsValid = rsp_valid;
        obsErr   = rsp_err;
        obsData  = rsp_rdata;
        obsDm0   = dm0;
    endtask

    task automatic idle();
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        obsValid = rsp_valid;
        obsDm0   = dm0;
    endtask

    task automatic doReset();
        @(negedge clk);
        req_valid = 1'b0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Count rising edges until req_ready rises, bounded so a stuck clear cannot hang the run.
    task automatic waitReady(output int cycles);
        cycles = 0;
        while (req_ready !== 1'b1 && cycles < 1000) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic test_reset();
        int cyc;
        #2 rst = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0 ||
            init_done !== EXP_INIT_IN_RESET || req_ready !== EXP_INIT_IN_RESET) begin
            miscompares++;
            $display("[TB] FAIL reset_state: valid=%b err=%b rdata=%h init=%b ready=%b, required 0 0 0 %b %b",
                     rsp_valid, rsp_err, rsp_rdata, init_done, req_ready,
                     EXP_INIT_IN_RESET, EXP_INIT_IN_RESET);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        waitReady(cyc);
        zeroModel();
    endtask

`ifdef DMEM_INIT_CLEAR_EN
    task automatic test_init_clear();
        int cyc;
        logic [31:0] chkAddr [2];
        chkAddr[0] = 32'h0;
        chkAddr[1] = 32'h3FC;
        doReset();
        waitReady(cyc);
        zeroModel();
        vectors++;
        if (cyc != DEPTH) begin
            miscompares++;
            $display("[TB] FAIL init_cycles: got %0d, required %0d", cyc, DEPTH);
        end
        issue(1'b0, 3'd2, 32'h3FC, 32'h0);
        vectors++;
        if (obsReady !== 1'b1 || obsValid !== 1'b1 || obsErr !== 1'b0 || obsData !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL init_lw3fc: ready=%b valid=%b err=%b data=%h, required 1 1 0 00000000",
                     obsReady, obsValid, obsErr, obsData);
        end
        issue(1'b1, 3'd2, 32'h0, 32'hDEADBEEF);
        issue(1'b1, 3'd2, 32'h3FC, 32'h12345678);
        doReset();
        repeat (100) @(posedge clk);
        #1;
        vectors++;
        if (req_ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midclear_ready: got %b, required 0", req_ready);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || init_done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midclear_reset: valid=%b init=%b, required 0 0", rsp_valid, init_done);
        end
        @(negedge clk);
        rst = 1'b1;
        waitReady(cyc);
        zeroModel();
        vectors++;
        if (cyc != DEPTH) begin
            miscompares++;
            $display("[TB] FAIL restart_cycles: got %0d, required %0d", cyc, DEPTH);
        end
        for (int i = 0; i < 2; i++) begin
            issue(1'b0, 3'd2, chkAddr[i], 32'h0);
            vectors++;
            if (obsValid !== 1'b1 || obsErr !== 1'b0 || obsData !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL recleared[%h]: valid=%b err=%b data=%h, required 1 0 00000000",
                         chkAddr[i], obsValid, obsErr, obsData);
            end
        end
        idle();
    endtask
`else
    task automatic test_fill();
        for (int w = 0; w < DEPTH; w++) begin
            issue(1'b1, 3'd2, 32'(4*w), $urandom);
            vectors++;
            if (obsReady !== 1'b1 || obsValid !== 1'b1 || obsErr !== 1'b0 || obsData !== 32'h0) begin
                miscompares++;
                $display("[TB] FAIL fill[%0d]: ready=%b valid=%b err=%b data=%h, required 1 1 0 00000000",
                         w, obsReady, obsValid, obsErr, obsData);
            end
        end
        idle();
    endtask

    task automatic test_preserve();
        logic [31:0] keep;
        keep = 32'hC0FFEE11;
        issue(1'b1, 3'd2, 32'h40, keep);
        idle();
        doReset();
        issue(1'b0, 3'd2, 32'h40, 32'h0);
        vectors++;
        if (obsReady !== 1'b1 || obsValid !== 1'b1 || obsData !== keep || obsData !== expData) begin
            miscompares++;
            $display("[TB] FAIL preserve: ready=%b valid=%b data=%h, required 1 1 %h",
                     obsReady, obsValid, obsData, keep);
        end
        idle();
    endtask
`endif

    task automatic test_extension();
        logic [2:0]  f3 [5];
        logic [31:0] ad [5];
        logic [31:0] ex [5];
        f3[0] = 3'd2; ad[0] = 32'h10; ex[0] = 32'h0;
        f3[1] = 3'd0; ad[1] = 32'h10; ex[1] = 32'hFFFFFFF3;
        f3[2] = 3'd4; ad[2] = 32'h13; ex[2] = 32'h00000080;
        f3[3] = 3'd1; ad[3] = 32'h12; ex[3] = 32'hFFFF8081;
        f3[4] = 3'd5; ad[4] = 32'h10; ex[4] = 32'h0000F2F3;
        for (int i = 0; i < 5; i++) begin
            issue(i == 0, f3[i], ad[i], 32'h8081F2F3);
            vectors++;
            if (obsValid !== 1'b1 || obsErr !== 1'b0 || obsData !== ex[i] || obsData !== expData) begin
                miscompares++;
                $display("[TB] FAIL ext[%0d]: valid=%b err=%b data=%h, required 1 0 %h",
                         i, obsValid, obsErr, obsData, ex[i]);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic        we [4];
        logic [2:0]  f3 [4];
        logic [31:0] ad [4];
        logic [31:0] wd [4];
        logic [31:0] ex [4];
        we[0] = 1; f3[0] = 3'd2; ad[0] = 32'h20; wd[0] = 32'h11223344; ex[0] = 32'h0;
        we[1] = 1; f3[1] = 3'd0; ad[1] = 32'h21; wd[1] = 32'h000000AA; ex[1] = 32'h0;
        we[2] = 1; f3[2] = 3'd1; ad[2] = 32'h22; wd[2] = 32'h0000BBCC; ex[2] = 32'h0;
        we[3] = 0; f3[3] = 3'd2; ad[3] = 32'h20; wd[3] = 32'h0;        ex[3] = 32'hBBCCAA44;
        for (int i = 0; i < 4; i++) begin
            issue(we[i], f3[i], ad[i], wd[i]);
            vectors++;
            if (obsValid !== 1'b1 || obsErr !== 1'b0 || obsData !== ex[i] || obsData !== expData) begin
                miscompares++;
                $display("[TB] FAIL b2b[%0d]: valid=%b err=%b data=%h, required 1 0 %h",
                         i, obsValid, obsErr, obsData, ex[i]);
            end
        end
        idle();
        vectors++;
        if (obsValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_pulse: valid after idle=%b, required 0", obsValid);
        end
    endtask

    task automatic test_faults();
        logic        we [7];
        logic [2:0]  f3 [7];
        logic [31:0] ad [7];
        logic [31:0] prev20;
        logic [31:0] prev0;
        prev20 = refWord(32'h20);
        prev0  = refWord(32'h0);
        we[0] = 0; f3[0] = 3'd2; ad[0] = 32'h22;
        we[1] = 1; f3[1] = 3'd1; ad[1] = 32'h01;
        we[2] = 0; f3[2] = 3'd2; ad[2] = 32'h400;
        we[3] = 0; f3[3] = 3'd3; ad[3] = 32'h20;
        we[4] = 1; f3[4] = 3'd3; ad[4] = 32'h20;
        we[5] = 1; f3[5] = 3'd2; ad[5] = 32'h400;
        we[6] = 1; f3[6] = 3'd2; ad[6] = 32'h22;
        for (int i = 0; i < 7; i++) begin
            issue(we[i], f3[i], ad[i], 32'h5A5A5A5A);
            vectors++;
            if (obsValid !== 1'b1 || obsErr !== 1'b1 || obsData !== 32'h0 || expErr !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL fault[%0d]: valid=%b err=%b data=%h, required 1 1 00000000",
                         i, obsValid, obsErr, obsData);
            end
        end
        issue(1'b0, 3'd2, 32'h20, 32'h0);
        vectors++;
        if (obsErr !== 1'b0 || obsData !== prev20) begin
            miscompares++;
            $display("[TB] FAIL fault_keep20: err=%b data=%h, required 0 %h", obsErr, obsData, prev20);
        end
        issue(1'b0, 3'd2, 32'h0, 32'h0);
        vectors++;
        if (obsErr !== 1'b0 || obsData !== prev0) begin
            miscompares++;
            $display("[TB] FAIL fault_keep0: err=%b data=%h, required 0 %h", obsErr, obsData, prev0);
        end
        idle();
    endtask

    task automatic test_dm0();
        issue(1'b1, 3'd2, 32'h0, 32'hDEADBEEF);
        vectors++;
        if (obsDm0 !== 32'hDEADBEEF) begin
            miscompares++;
            $display("[TB] FAIL dm0_sw: got %h, required DEADBEEF", obsDm0);
        end
        issue(1'b1, 3'd0, 32'h3, 32'h00000011);
        vectors++;
        if (obsDm0 !== 32'h11ADBEEF || obsDm0 !== refWord(0)) begin
            miscompares++;
            $display("[TB] FAIL dm0_sb: got %h, required 11ADBEEF", obsDm0);
        end
        idle();
    endtask

    task automatic test_reset_mid_transaction();
        int cyc;
        issue(1'b1, 3'd2, 32'h30, 32'hA5A5F00F);
        issue(1'b0, 3'd2, 32'h30, 32'h0);
        vectors++;
        if (obsValid !== 1'b1 || obsData !== 32'hA5A5F00F) begin
            miscompares++;
            $display("[TB] FAIL midtxn_pre: valid=%b data=%h, required 1 a5a5f00f", obsValid, obsData);
        end
        #1;
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_rdata !== 32'h0) begin
            miscompares++;
            $display("[TB] FAIL midtxn_reset: valid=%b err=%b data=%h, required 0 0 00000000",
                     rsp_valid, rsp_err, rsp_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midtxn_after: valid=%b, required 0", rsp_valid);
        end
        waitReady(cyc);
`ifdef DMEM_INIT_CLEAR_EN
        zeroModel();
`endif
    endtask

    task automatic test_random();
        logic [2:0]  ldF3 [8];
        logic [2:0]  stF3 [6];
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        int          sel;
        ldF3[0] = 3'd0; ldF3[1] = 3'd1; ldF3[2] = 3'd2; ldF3[3] = 3'd4;
        ldF3[4] = 3'd5; ldF3[5] = 3'd3; ldF3[6] = 3'd6; ldF3[7] = 3'd7;
        stF3[0] = 3'd0; stF3[1] = 3'd1; stF3[2] = 3'd2;
        stF3[3] = 3'd3; stF3[4] = 3'd6; stF3[5] = 3'd7;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                idle();
                vectors++;
                if (obsValid !== 1'b0 || obsDm0 !== refWord(0)) begin
                    miscompares++;
                    $display("[TB] FAIL rnd_idle[%0d]: valid=%b dm0=%h, required 0 %h",
                             n, obsValid, obsDm0, refWord(0));
                end
            end else begin
                we = ($urandom_range(0, 1) == 1);
                if (we) begin
                    sel = (($urandom_range(0, 9)) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 5);
                    f3 = stF3[sel];
                end else begin
                    sel = (($urandom_range(0, 9)) < 8) ? $urandom_range(0, 4) : $urandom_range(5, 7);
                    f3 = ldF3[sel];
                end
                sel = $urandom_range(0, 9);
                if (sel < 7)       addr = 32'($urandom_range(0, 63));
                else if (sel < 9)  addr = 32'($urandom_range(0, 4*DEPTH - 1));
                else               addr = 32'($urandom_range(0, 8*DEPTH - 1));
                issue(we, f3, addr, $urandom);
                vectors++;
                if (obsReady !== 1'b1 || obsValid !== 1'b1 || obsErr !== expErr ||
                    obsData !== expData || obsDm0 !== refWord(0)) begin
                    miscompares++;
                    $display("[TB] FAIL rnd[%0d] we=%b f3=%0d addr=%h: valid=%b err=%b data=%h dm0=%h, required 1 %b %h %h",
                             n, we, f3, addr, obsValid, obsErr, obsData, obsDm0,
                             expErr, expData, refWord(0));
                end
            end
        end
        idle();
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
`ifdef DMEM_INIT_CLEAR_EN
        test_init_clear();
`else
        test_fill();
`endif
        test_extension();
        test_back_to_back();
        test_faults();
        test_dm0();
        test_reset_mid_transaction();
`ifndef DMEM_INIT_CLEAR_EN
        test_preserve();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
